// File: rtl/button_conditioner_pkg.sv
// Shared constants for the button conditioner:
// repeat-FSM state encodings and width helpers.
package button_conditioner_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DELAY = 2'd1;
  localparam logic [1:0] ST_RPT   = 2'd2;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v)
      r = r + 1;
    return r;
  endfunction

  function automatic int imax(
    input int a,
    input int b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Button bundle: raw levels in, conditioned
// levels and event strobes out.
interface button_conditioner_if #(
  parameter int NUM_CH = 4
);

  logic [NUM_CH-1:0] i_Switch;
  logic [NUM_CH-1:0] o_Switch;
  logic [NUM_CH-1:0] o_Press;
  logic [NUM_CH-1:0] o_Release;
  logic [NUM_CH-1:0] o_Repeat;
  logic [NUM_CH-1:0] o_Action;

  modport master (
    output i_Switch,
    input  o_Switch,
    input  o_Press,
    input  o_Release,
    input  o_Repeat,
    input  o_Action
  );

  modport slave (
    input  i_Switch,
    output o_Switch,
    output o_Press,
    output o_Release,
    output o_Repeat,
    output o_Action
  );

endinterface

// File: rtl/button_conditioner_debounce_channel.sv
// One button: 2-flop sync, debounce counter,
// press/release strobes and hold-to-repeat FSM.
module debounce_channel
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int REPEAT_DELAY   = 12500000,
  parameter int REPEAT_PERIOD  = 2500000
) (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_Switch,
  output logic o_Switch,
  output logic o_Press,
  output logic o_Release,
  output logic o_Repeat
);

  localparam int CW =
    clog2(DEBOUNCE_LIMIT + 1);
  localparam int HW =
    clog2(imax(REPEAT_DELAY,
               REPEAT_PERIOD) + 1);
  localparam bit RPT_EN =
    (REPEAT_DELAY != 0);

  localparam logic [CW-1:0] DB_LAST =
    CW'(DEBOUNCE_LIMIT - 1);
  localparam logic [HW-1:0] D_LAST =
    HW'(RPT_EN ? REPEAT_DELAY - 1 : 0);
  localparam logic [HW-1:0] P_LAST =
    HW'(REPEAT_PERIOD - 1);

  logic          sync1;
  logic          s;
  logic [CW-1:0] cnt;
  logic [1:0]    state;
  logic [HW-1:0] hold;

  logic flip;
  logic rise;
  logic fall;

  // A new level is accepted on the last
  // cycle of an unbroken mismatch run.
  assign flip = (s != o_Switch) &&
                (cnt == DB_LAST);
  assign rise = flip & s;
  assign fall = flip & ~s;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      sync1     <= 1'b0;
      s         <= 1'b0;
      cnt       <= '0;
      o_Switch  <= 1'b0;
      o_Press   <= 1'b0;
      o_Release <= 1'b0;
      o_Repeat  <= 1'b0;
      state     <= ST_IDLE;
      hold      <= '0;
    end else begin
      sync1     <= i_Switch;
      s         <= sync1;
      o_Press   <= rise;
      o_Release <= fall;
      o_Repeat  <= 1'b0;

      if (s == o_Switch) begin
        cnt <= '0;
      end else if (flip) begin
        o_Switch <= s;
        cnt      <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end

      // Release wins over any tick due now.
      if (fall) begin
        state <= ST_IDLE;
        hold  <= '0;
      end else begin
        unique case (1'b1)
          (state == ST_IDLE): begin
            if (rise && RPT_EN) begin
              state <= ST_DELAY;
              hold  <= '0;
            end
          end
          (state == ST_DELAY): begin
            if (hold == D_LAST) begin
              o_Repeat <= 1'b1;
              hold     <= '0;
              state    <= ST_RPT;
            end else begin
              hold <= hold + 1'b1;
            end
          end
          (state == ST_RPT): begin
            if (hold == P_LAST) begin
              o_Repeat <= 1'b1;
              hold     <= '0;
            end else begin
              hold <= hold + 1'b1;
            end
          end
          default: begin
            state <= ST_IDLE;
            hold  <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel button conditioner: one
// debounce_channel per bit plus action strobe.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int REPEAT_DELAY   = 12500000,
  parameter int REPEAT_PERIOD  = 2500000
) (
  input logic           i_Clk,
  input logic           i_Reset,
  button_conditioner_if.slave bus
);

  logic [NUM_CH-1:0] sw;
  logic [NUM_CH-1:0] press;
  logic [NUM_CH-1:0] rel;
  logic [NUM_CH-1:0] rpt;

  for (genvar g = 0; g < NUM_CH; g++)
  begin : g_ch
    debounce_channel #(
      .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_ch (
      .i_Clk    (i_Clk),
      .i_Reset  (i_Reset),
      .i_Switch (bus.i_Switch[g]),
      .o_Switch (sw[g]),
      .o_Press  (press[g]),
      .o_Release(rel[g]),
      .o_Repeat (rpt[g])
    );
  end

  assign bus.o_Switch  = sw;
  assign bus.o_Press   = press;
  assign bus.o_Release = rel;
  assign bus.o_Repeat  = rpt;
  // Both terms are flops and never
  // coincide, so this is a clean strobe.
  assign bus.o_Action  = press | rpt;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner,
// including a repeat-disabled build.
module tb_button_conditioner;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  button_conditioner_if #(.NUM_CH(4)) bus ();
  button_conditioner_if #(.NUM_CH(4)) bus2 ();

  button_conditioner #(
    .NUM_CH        (4),
    .DEBOUNCE_LIMIT(4),
    .REPEAT_DELAY  (10),
    .REPEAT_PERIOD (3)
  ) dut (
    .i_Clk  (clk),
    .i_Reset(rst),
    .bus    (bus)
  );

  button_conditioner #(
    .NUM_CH        (4),
    .DEBOUNCE_LIMIT(4),
    .REPEAT_DELAY  (0),
    .REPEAT_PERIOD (3)
  ) dut_norpt (
    .i_Clk  (clk),
    .i_Reset(rst),
    .bus    (bus2)
  );

  task automatic chk(
    input string      tag,
    input logic [3:0] obs,
    input logic [3:0] exp
  );
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [3:0] bit_if(
    input bit   c,
    input int   ch
  );
    logic [3:0] v;
    v = 4'b0000;
    if (c) v[ch] = 1'b1;
    return v;
  endfunction

  initial begin
    rst = 1'b1;
    bus.i_Switch  = 4'b1111;
    bus2.i_Switch = 4'b0000;

    // 1: outputs held at 0 through reset
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_sw",  bus.o_Switch,  4'b0000);
      chk("rst_prs", bus.o_Press,   4'b0000);
      chk("rst_rel", bus.o_Release, 4'b0000);
      chk("rst_rpt", bus.o_Repeat,  4'b0000);
      chk("rst_act", bus.o_Action,  4'b0000);
    end
    rst = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      step();
      chk("t1_sw", bus.o_Switch,
          (i >= 6) ? 4'b1111 : 4'b0000);
      chk("t1_prs", bus.o_Press,
          (i == 6) ? 4'b1111 : 4'b0000);
      chk("t1_act", bus.o_Action,
          (i == 6) ? 4'b1111 : 4'b0000);
    end
    bus.i_Switch = 4'b0000;
    for (int i = 1; i <= 7; i++) begin
      step();
      chk("t1_rel", bus.o_Release,
          (i == 6) ? 4'b1111 : 4'b0000);
      chk("t1_rpt", bus.o_Repeat, 4'b0000);
    end

    // 2: 1-cycle toggling never accepted
    for (int i = 0; i < 30; i++) begin
      bus.i_Switch[0] = (i < 20) && (i % 2 == 0);
      step();
      chk("t2_sw",  bus.o_Switch  & 4'b0001,
          4'b0000);
      chk("t2_prs", bus.o_Press   & 4'b0001,
          4'b0000);
      chk("t2_rel", bus.o_Release & 4'b0001,
          4'b0000);
    end

    // 3: 3-cycle high, glitch low, then stable
    bus.i_Switch[1] = 1'b1;
    step();
    step();
    step();
    bus.i_Switch[1] = 1'b0;
    step();
    chk("t3_early", bus.o_Switch, 4'b0000);
    bus.i_Switch[1] = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      chk("t3_prs", bus.o_Press,
          bit_if(i == 6, 1));
      chk("t3_sw", bus.o_Switch,
          bit_if(i == 6, 1));
    end
    bus.i_Switch[1] = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      step();
      chk("t3_rel", bus.o_Release,
          bit_if(i == 6, 1));
      chk("t3_rpt", bus.o_Repeat, 4'b0000);
    end

    // 4: hold-to-repeat then release
    bus.i_Switch[2] = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      chk("t4_prs", bus.o_Press,
          bit_if(i == 6, 2));
    end
    chk("t4_act0", bus.o_Action, 4'b0100);
    for (int t = 1; t <= 60; t++) begin
      if (t == 41) bus.i_Switch[2] = 1'b0;
      step();
      chk("t4_rpt", bus.o_Repeat,
          bit_if(t >= 10 && t < 46 &&
                 (t - 10) % 3 == 0, 2));
      chk("t4_act", bus.o_Action,
          bit_if(t >= 10 && t < 46 &&
                 (t - 10) % 3 == 0, 2));
      chk("t4_rel", bus.o_Release,
          bit_if(t == 46, 2));
      chk("t4_prs_quiet", bus.o_Press, 4'b0000);
    end

    // 5: reset during DELAY restarts timing
    bus.i_Switch[3] = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      chk("t5_prs", bus.o_Press,
          bit_if(i == 6, 3));
    end
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_rst_sw",  bus.o_Switch,  4'b0000);
    chk("t5_rst_prs", bus.o_Press,   4'b0000);
    chk("t5_rst_rpt", bus.o_Repeat,  4'b0000);
    chk("t5_rst_rel", bus.o_Release, 4'b0000);
    for (int i = 1; i <= 6; i++) begin
      step();
      chk("t5_reprs", bus.o_Press,
          bit_if(i == 6, 3));
      chk("t5_resw", bus.o_Switch,
          bit_if(i == 6, 3));
    end
    for (int t = 1; t <= 16; t++) begin
      step();
      chk("t5_rpt", bus.o_Repeat,
          bit_if(t == 10 || t == 13 ||
                 t == 16, 3));
    end
    bus.i_Switch[3] = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("t5_rel_rpt", bus.o_Repeat,
          bit_if(i == 3, 3));
      chk("t5_rel", bus.o_Release,
          bit_if(i == 6, 3));
    end

    // 6: repeat disabled build
    bus2.i_Switch = 4'b1111;
    for (int i = 1; i <= 6; i++) begin
      step();
      chk("t6_prs", bus2.o_Press,
          (i == 6) ? 4'b1111 : 4'b0000);
    end
    for (int i = 0; i < 100; i++) begin
      step();
      chk("t6_rpt", bus2.o_Repeat, 4'b0000);
      chk("t6_prs_once", bus2.o_Press, 4'b0000);
      chk("t6_sw", bus2.o_Switch, 4'b1111);
    end

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
